fft_twiddle_sequencer: RTL and testbench
========================================

Name: fft_twiddle_sequencer

Overview:
- Sequences one complete radix-2 decimation-in-time FFT/IFFT pass of 2^FFT_N points.
- Per butterfly, drives the twiddle ROM bridge request port with tact_rom, ta_rom, evenOdd and ifft.
- Emits butterfly operand addresses delayed by 3 cycles so they line up with the bridge's tdr_rom_real/tdr_rom_imag.
- Sits between the FFT top-level control and the butterfly datapath and sample RAM.

Parameters:
- FFT_N, 10, log2 of the point count; legal range 4..12.
- STAGE_GAP, 4, idle cycles between stages so the butterfly datapath can drain; 0 is legal.
- SW, $clog2(FFT_N), width of the stage index (derived, not overridable).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a pass; ignored while busy
- ifft_in  in  1  transform direction, sampled on an accepted start
- hold  in  1  back-pressure; suppresses new butterfly issue
- tact_rom  out  1  twiddle request strobe to the bridge
- ta_rom  out  FFT_N-1  twiddle index 0..2^(FFT_N-1)-1
- evenOdd  out  1  issue-phase flag to the bridge; 0 on every issue cycle
- ifft  out  1  latched direction, to the bridge
- bf_valid  out  1  aligned butterfly valid (issue+3)
- bf_addr_a  out  FFT_N  aligned upper-leg sample address
- bf_addr_b  out  FFT_N  aligned lower-leg sample address
- bf_stage  out  SW  aligned stage index
- bf_last  out  1  aligned flag marking the final butterfly of the pass
- busy  out  1  pass in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: async assert returns FSM to IDLE; all outputs and internal counters reset to 0 immediately.
  - An aborted pass emits no further bf_valid or done.
- States: IDLE, RUN, GAP, DRAIN.
- IDLE
  - start=1 at an edge: latch ifft_in into ifft; clear stage s=0, butterfly k=0 and phase=0; go to RUN.
  - busy rises the same edge.
- RUN
  - phase toggles every cycle.
  - Issue cycle = phase 0 and hold=0: tact_rom=1, evenOdd=0, then k increments.
  - phase 0 with hold=1: tact_rom=0 and k holds; the next issue opportunity is 2 cycles later.
  - phase 1: tact_rom=0, evenOdd=1. This gives the bridge its sin-read slot and prevents ROM port conflict.
- Issue address math, for stage s, half = 2^s, j = k>>s, p = k & (half-1):
  - addr_a = j*2*half + p
  - addr_b = addr_a + half
  - ta_rom = p << (FFT_N-1-s), truncated to FFT_N-1 bits.
- Stage end: after the issue with k = 2^(FFT_N-1)-1, the next cycle is the phase-1 slot.
  - Then GAP if s < FFT_N-1; otherwise DRAIN.
  - With STAGE_GAP=0, GAP is skipped and RUN resumes at phase 0 with s+1 and k=0.
- GAP
  - Counts exactly STAGE_GAP cycles regardless of hold, with tact_rom=0.
  - Then s increments, k=0, phase=0, return to RUN.
- Alignment pipeline: 3 registers carry valid, addresses, stage and last from each issue.
  - They never stall, matching the bridge's fixed latency; bf_* outputs are registered.
  - bf_last is set on the issue with s=FFT_N-1 and k=2^(FFT_N-1)-1.
- DRAIN: waits until the cycle after bf_last is output; then done=1 for 1 cycle, busy=0 the same cycle, go to IDLE.
- start during busy: ignored; ifft is unchanged.
- ifft is held constant for the whole pass.
- Zero-hold pass length from the start edge to done:
  - FFT_N*(2^FFT_N) + (FFT_N-1)*STAGE_GAP + 4 cycles.

Test Plan:
- FFT_N=4, STAGE_GAP=0, start, hold=0:
  - Stage 0: ta_rom=0 ×8, a=0,2,..14, b=a+1.
  - Stage 1: ta_rom=0,4,0,4,…, a=0,1,4,5,8,9,12,13.
  - Stage 2: ta_rom=0,2,4,6,0,2,4,6, a=0,1,2,3,8,9,10,11, b=a+4.
  - Stage 3: ta_rom=0..7, a=0..7, b=a+8.
  - Issues on cycles 1,3,5,…; done on cycle 68.
- Alignment: for every issue at cycle t, bf_valid and bf_addr_a are observed at t+3; bf_last appears exactly once, on the 32nd bf_valid.
- FFT_N=4, STAGE_GAP=3: exactly 3 extra tact_rom=0 cycles after each stage's phase-1 slot; done on cycle 77.
- hold=1 for cycles 5..8 in stage 0:
  - Issues at 1, 3, then 9 (no issue at 5 or 7); tact_rom never asserted with evenOdd=1.
  - Address sequence unchanged; done delayed 4 cycles.
- Control inputs:
  - ifft_in=1 at start, toggled mid-pass: ifft stays 1 all pass.
  - Second start mid-pass: ignored, with no restart and k unaffected.
- rst pulse mid-stage 2 (async, between edges): all outputs 0 immediately, no done, IDLE.
  - A following start runs a full, correct pass.

Source files
------------

// File: rtl/fft_twiddle_sequencer.sv
// Radix-2 DIT FFT pass sequencer: issues twiddle requests to the ROM bridge
// and emits butterfly addresses aligned to the bridge's 3-cycle read latency.
module fft_twiddle_sequencer #(
    parameter  int FFT_N     = 10,
    parameter  int STAGE_GAP = 4,
    localparam int SW        = $clog2(FFT_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ifft_in,
    input  logic             hold,
    output logic             tact_rom,
    output logic [FFT_N-2:0] ta_rom,
    output logic             evenOdd,
    output logic             ifft,
    output logic             bf_valid,
    output logic [FFT_N-1:0] bf_addr_a,
    output logic [FFT_N-1:0] bf_addr_b,
    output logic [SW-1:0]    bf_stage,
    output logic             bf_last,
    output logic             busy,
    output logic             done
);

    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [GW-1:0]    GAP_LAST = GW'(STAGE_GAP - 1);
    localparam logic [SW-1:0]    LAST_S   = SW'(FFT_N - 1);
    localparam logic [FFT_N-1:0] KEND     = FFT_N'(1) << (FFT_N - 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DRAIN} state_t;

    typedef struct packed {
        logic             valid;
        logic [FFT_N-1:0] a;
        logic [FFT_N-1:0] b;
        logic [SW-1:0]    stage;
        logic             last;
    } bf_t;

    state_t           state, state_n;
    logic [SW-1:0]    s, s_n;
    logic [FFT_N-1:0] k, k_n;
    logic             phase, phase_n;
    logic [GW-1:0]    gap_cnt, gap_cnt_n;
    logic             ifft_n;
    logic             last_seen, last_seen_n;
    logic             done_n;
    logic             issue;

    logic [FFT_N-1:0] kx, jx, px, mask, half, addr_a, addr_b;
    logic [SW-1:0]    sh;
    bf_t              bf_in;
    bf_t              pipe [3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            s         <= '0;
            k         <= '0;
            phase     <= 1'b0;
            gap_cnt   <= '0;
            ifft      <= 1'b0;
            last_seen <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            s         <= s_n;
            k         <= k_n;
            phase     <= phase_n;
            gap_cnt   <= gap_cnt_n;
            ifft      <= ifft_n;
            last_seen <= last_seen_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        s_n         = s;
        k_n         = k;
        phase_n     = phase;
        gap_cnt_n   = gap_cnt;
        ifft_n      = ifft;
        last_seen_n = last_seen;
        done_n      = 1'b0;
        issue       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = RUN;
                    ifft_n      = ifft_in;
                    s_n         = '0;
                    k_n         = '0;
                    phase_n     = 1'b0;
                    last_seen_n = 1'b0;
                end
            end
            RUN: begin
                phase_n = ~phase;
                if (!phase) begin
                    if (!hold) begin
                        issue = 1'b1;
                        k_n   = k + FFT_N'(1);
                    end
                end else if (k == KEND) begin
                    // stage complete once the phase-1 slot after the last issue passes
                    k_n     = '0;
                    phase_n = 1'b0;
                    if (s == LAST_S) begin
                        state_n = DRAIN;
                    end else if (STAGE_GAP == 0) begin
                        s_n = s + SW'(1);
                    end else begin
                        state_n   = GAP;
                        gap_cnt_n = '0;
                    end
                end
            end
            GAP: begin
                gap_cnt_n = gap_cnt + GW'(1);
                if (gap_cnt == GAP_LAST) begin
                    state_n = RUN;
                    s_n     = s + SW'(1);
                    k_n     = '0;
                    phase_n = 1'b0;
                end
            end
            DRAIN: begin
                if (bf_last) last_seen_n = 1'b1;
                if (last_seen) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        kx     = {1'b0, k[FFT_N-2:0]};
        half   = FFT_N'(1) << s;
        mask   = half - FFT_N'(1);
        jx     = kx >> s;
        px     = kx & mask;
        addr_a = ((jx << s) << 1) | px;
        addr_b = addr_a + half;
        sh     = LAST_S - s;
    end

    assign tact_rom = issue;
    assign ta_rom   = px[FFT_N-2:0] << sh;
    assign evenOdd  = (state == RUN) && phase;
    assign busy     = (state != IDLE);

    always_comb begin
        bf_in.valid = issue;
        bf_in.a     = addr_a;
        bf_in.b     = addr_b;
        bf_in.stage = s;
        bf_in.last  = issue && (s == LAST_S) && (k == KEND - FFT_N'(1));
    end

    // fixed-latency alignment to the bridge's twiddle data; never stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe[0] <= '0;
            pipe[1] <= '0;
            pipe[2] <= '0;
        end else begin
            pipe[0] <= bf_in;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
    end

    assign bf_valid  = pipe[2].valid;
    assign bf_addr_a = pipe[2].a;
    assign bf_addr_b = pipe[2].b;
    assign bf_stage  = pipe[2].stage;
    assign bf_last   = pipe[2].last;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed scoreboard bench for fft_twiddle_sequencer with FFT_N=4,
// STAGE_GAP 0 and 3 instances.
module tb_fft_twiddle_sequencer;

    logic clk = 1'b0;
    logic rst, start0, start3, ifft_in, hold, g3;

    logic       t0_tact, t0_eo, t0_ifft, t0_v, t0_last, t0_busy, t0_done;
    logic [2:0] t0_ta;
    logic [3:0] t0_a, t0_b;
    logic [1:0] t0_st;
    logic       t3_tact, t3_eo, t3_ifft, t3_v, t3_last, t3_busy, t3_done;
    logic [2:0] t3_ta;
    logic [3:0] t3_a, t3_b;
    logic [1:0] t3_st;

    logic       m_tact, m_eo, m_ifft, m_v, m_last, m_busy, m_done;
    logic [2:0] m_ta;
    logic [3:0] m_a, m_b;
    logic [1:0] m_st;

    always #5 clk = ~clk;

    fft_twiddle_sequencer #(.FFT_N(4), .STAGE_GAP(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .ifft_in(ifft_in), .hold(hold),
        .tact_rom(t0_tact), .ta_rom(t0_ta), .evenOdd(t0_eo), .ifft(t0_ifft),
        .bf_valid(t0_v), .bf_addr_a(t0_a), .bf_addr_b(t0_b),
        .bf_stage(t0_st), .bf_last(t0_last), .busy(t0_busy), .done(t0_done)
    );

    fft_twiddle_sequencer #(.FFT_N(4), .STAGE_GAP(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .ifft_in(ifft_in), .hold(hold),
        .tact_rom(t3_tact), .ta_rom(t3_ta), .evenOdd(t3_eo), .ifft(t3_ifft),
        .bf_valid(t3_v), .bf_addr_a(t3_a), .bf_addr_b(t3_b),
        .bf_stage(t3_st), .bf_last(t3_last), .busy(t3_busy), .done(t3_done)
    );

    assign m_tact = g3 ? t3_tact : t0_tact;
    assign m_eo   = g3 ? t3_eo   : t0_eo;
    assign m_ifft = g3 ? t3_ifft : t0_ifft;
    assign m_v    = g3 ? t3_v    : t0_v;
    assign m_last = g3 ? t3_last : t0_last;
    assign m_busy = g3 ? t3_busy : t0_busy;
    assign m_done = g3 ? t3_done : t0_done;
    assign m_ta   = g3 ? t3_ta   : t0_ta;
    assign m_a    = g3 ? t3_a    : t0_a;
    assign m_b    = g3 ? t3_b    : t0_b;
    assign m_st   = g3 ? t3_st   : t0_st;

    typedef struct {
        int due;
        int a;
        int b;
        int s;
        bit last;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tact"}, 32'(m_tact), 0);
        chk({tag, "_ta"}, 32'(m_ta), 0);
        chk({tag, "_eo"}, 32'(m_eo), 0);
        chk({tag, "_ifft"}, 32'(m_ifft), 0);
        chk({tag, "_valid"}, 32'(m_v), 0);
        chk({tag, "_a"}, 32'(m_a), 0);
        chk({tag, "_b"}, 32'(m_b), 0);
        chk({tag, "_stage"}, 32'(m_st), 0);
        chk({tag, "_last"}, 32'(m_last), 0);
        chk({tag, "_busy"}, 32'(m_busy), 0);
        chk({tag, "_done"}, 32'(m_done), 0);
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) start3 = v;
        else start0 = v;
    endtask

    // One pass; expected issue cycles and addresses come from the pass
    // timing and butterfly address formulas. Cycle c is the clock period
    // ending at the c-th edge after the start edge.
    task automatic run_pass(input bit sel, input int gap, input int h0,
                            input int h1, input int hshift, input bit ifv,
                            input int abort_at);
        int iss[32];
        int done_c, en, s, k, half, a, b, ta;
        bit ev;
        exp_t e;
        g3 = sel;
        for (int n = 0; n < 32; n++) begin
            iss[n] = 1 + (n / 8) * (16 + gap) + 2 * (n % 8);
            if (h1 > 0 && iss[n] >= h0) iss[n] += hshift;
        end
        done_c = 64 + 3 * gap + 4 + hshift;
        q.delete();
        @(posedge clk);
        #1;
        ifft_in = ifv;
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
        for (int c = 1; c <= done_c + 2; c++) begin
            hold = (c >= h0 && c <= h1);
            if (c == 20) ifft_in = ~ifv;
            if (c == 30) set_start(sel, 1'b1);
            if (c == 31) set_start(sel, 1'b0);
            @(negedge clk);
            en = -1;
            for (int n = 0; n < 32; n++) if (iss[n] == c) en = n;
            chk("tact_rom", 32'(m_tact), 32'(en >= 0));
            chk("no_conflict", 32'(m_tact & m_eo), 0);
            if (en >= 0) begin
                s    = en / 8;
                k    = en % 8;
                half = 1 << s;
                a    = (k >> s) * 2 * half + (k % half);
                b    = a + half;
                ta   = ((k % half) << (3 - s)) & 7;
                chk("ta_rom", 32'(m_ta), ta);
                chk("evenOdd", 32'(m_eo), 0);
                q.push_back('{due: c + 3, a: a, b: b, s: s, last: (en == 31)});
            end
            ev = (q.size() > 0) && (q[0].due == c);
            chk("bf_valid", 32'(m_v), 32'(ev));
            if (ev) begin
                e = q.pop_front();
                chk("bf_addr_a", 32'(m_a), e.a);
                chk("bf_addr_b", 32'(m_b), e.b);
                chk("bf_stage", 32'(m_st), e.s);
                chk("bf_last", 32'(m_last), 32'(e.last));
            end
            chk("busy", 32'(m_busy), 32'(c < done_c));
            chk("done", 32'(m_done), 32'(c == done_c));
            chk("ifft", 32'(m_ifft), 32'(ifv));
            if (c == abort_at) begin
                #1 rst = 1'b1;
                #1 check_zero("abort");
                #1 rst = 1'b0;
                hold = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        hold = 1'b0;
        chk("sb_empty", 32'(q.size()), 0);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start3 = 1'b0;
        ifft_in = 1'b0;
        hold = 1'b0;
        g3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        g3 = 1'b0;
        #1 check_zero("rst0");
        g3 = 1'b1;
        #1 check_zero("rst3");
        rst = 1'b0;

        run_pass(1'b0, 0, 0, 0, 0, 1'b1, 0);
        run_pass(1'b1, 3, 0, 0, 0, 1'b0, 0);
        run_pass(1'b0, 0, 5, 8, 4, 1'b1, 0);
        run_pass(1'b0, 0, 0, 0, 0, 1'b1, 40);

        g3 = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("post_abort_valid", 32'(m_v), 0);
            chk("post_abort_done", 32'(m_done), 0);
            chk("post_abort_busy", 32'(m_busy), 0);
            chk("post_abort_tact", 32'(m_tact), 0);
        end

        run_pass(1'b0, 0, 0, 0, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
